// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// reg_write_arbiter_if : request/grant bus between the game-logic requesters,
//                        the write arbiter and the register bank.
// Revision 1.0
// ============================================================================
interface reg_write_arbiter_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int ADDRW = 2
);
    logic [3:0]         req;
    logic [4*ADDRW-1:0] req_addr;
    logic [4*N-1:0]     req_data;
    logic [3:0]         grant;
    logic [3:0]         done;
    logic [DEPTH-1:0]   wr_en;
    logic [N-1:0]       wr_data;
    logic               busy;

    modport master (
        output req, req_addr, req_data,
        input  grant, done, wr_en, wr_data, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output grant, done, wr_en, wr_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// reg_write_arbiter : round-robin arbiter sharing the register-bank write port
//                     among four requesters (IDLE -> WRITE -> ACK per write).
// Revision 1.0
// ============================================================================
module reg_write_arbiter #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int ADDRW = 2
) (
    input wire                 clk,
    input wire                 reset,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       r_win, w_win_nxt;
    logic [3:0]       r_grant, w_grant_nxt;
    logic [3:0]       r_done, w_done_nxt;
    logic [DEPTH-1:0] r_wr_en, w_wr_en_nxt;
    logic [N-1:0]     r_wr_data, w_wr_data_nxt;

    logic             w_found;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;
    logic [ADDRW-1:0] w_sel_addr;
    logic [N-1:0]     w_sel_data;
    logic [DEPTH-1:0] w_dec;

    // Search starts just after the last winner, so the last winner ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_sel_addr = bus.req_addr[int'(w_pick)*ADDRW +: ADDRW];
    assign w_sel_data = bus.req_data[int'(w_pick)*N +: N];

    // Addresses at or beyond DEPTH decode to no enable at all.
    always_comb begin
        w_dec = '0;
        for (int d = 0; d < DEPTH; d++) begin
            if (w_sel_addr == ADDRW'(d)) begin
                w_dec[d] = 1'b1;
            end
        end
    end

    // Outputs are registered, so each state computes the values seen in the next one.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_grant_nxt   = '0;
        w_done_nxt    = '0;
        w_wr_en_nxt   = '0;
        w_wr_data_nxt = r_wr_data;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt   = WRITE;
                    w_win_nxt     = w_pick;
                    w_grant_nxt   = 4'b0001 << w_pick;
                    w_wr_en_nxt   = w_dec;
                    w_wr_data_nxt = w_sel_data;
                end
            end
            WRITE: begin
                w_state_nxt = ACK;
                w_grant_nxt = 4'b0001 << r_win;
                w_done_nxt  = 4'b0001 << r_win;
            end
            ACK: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = r_win;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd3;
            r_win     <= 2'd0;
            r_grant   <= '0;
            r_done    <= '0;
            r_wr_en   <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_write_arbiter : directed + random bench for two arbiters (DEPTH 4 and
//                        DEPTH 3) against a transaction-timestamp reference.
// Revision 1.0
// ============================================================================
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N(8), .DEPTH(4), .ADDRW(2)) bus4 ();
    reg_write_arbiter_if #(.N(8), .DEPTH(3), .ADDRW(2)) bus3 ();

    assign bus3.req      = bus4.req;
    assign bus3.req_addr = bus4.req_addr;
    assign bus3.req_data = bus4.req_data;

    reg_write_arbiter #(.N(8), .DEPTH(4), .ADDRW(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    reg_write_arbiter #(.N(8), .DEPTH(3), .ADDRW(2)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    // Reference: a transaction is a winner plus the edge it was granted at.
    int         cyc   = 0;
    int         ts    = -10;
    bit         act   = 1'b0;
    logic [1:0] last  = 2'd3;
    logic [1:0] win   = 2'd0;
    logic [1:0] laddr = 2'd0;
    logic [7:0] ldata = 8'd0;
    logic [7:0] e_wd  = 8'd0;
    logic [3:0] e_grant = 4'd0;
    logic [3:0] e_done  = 4'd0;
    logic [3:0] e_wen4  = 4'd0;
    logic [2:0] e_wen3  = 3'd0;
    logic       e_busy  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [1:0] idx;
        bit         found;
        if (!reset) begin
            act  = 1'b0;
            last = 2'd3;
            e_wd = 8'd0;
        end else if (act && cyc == ts + 2) begin
            act  = 1'b0;
            last = win;
        end else if (!act && bus4.req != 4'd0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = 2'((int'(last) + k) % 4);
                if (!found && bus4.req[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            laddr = bus4.req_addr[int'(win)*2 +: 2];
            ldata = bus4.req_data[int'(win)*8 +: 8];
            ts    = cyc;
            act   = 1'b1;
            e_wd  = ldata;
        end
        e_grant = act ? 4'(1 << win) : 4'd0;
        e_done  = (act && cyc == ts + 1) ? 4'(1 << win) : 4'd0;
        e_wen4  = (act && cyc == ts && int'(laddr) < 4) ? 4'(1 << laddr) : 4'd0;
        e_wen3  = (act && cyc == ts && int'(laddr) < 3) ? 3'(1 << laddr) : 3'd0;
        e_busy  = act;
        cyc++;
    endtask

    task automatic compare_all();
        chk("grant4",   32'(bus4.grant),   32'(e_grant));
        chk("done4",    32'(bus4.done),    32'(e_done));
        chk("wr_en4",   32'(bus4.wr_en),   32'(e_wen4));
        chk("wr_data4", 32'(bus4.wr_data), 32'(e_wd));
        chk("busy4",    32'(bus4.busy),    32'(e_busy));
        chk("grant3",   32'(bus3.grant),   32'(e_grant));
        chk("done3",    32'(bus3.done),    32'(e_done));
        chk("wr_en3",   32'(bus3.wr_en),   32'(e_wen3));
        chk("wr_data3", 32'(bus3.wr_data), 32'(e_wd));
        chk("busy3",    32'(bus3.busy),    32'(e_busy));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_slot(input int i, input logic [1:0] a, input logic [7:0] d);
        bus4.req_addr[i*2 +: 2] = a;
        bus4.req_data[i*8 +: 8] = d;
    endtask

    initial begin
        int n_done;
        reset         = 1'b0;
        bus4.req      = 4'b1111;
        bus4.req_addr = 8'hE4;
        bus4.req_data = 32'h44332211;

        // Reset held with all requests pending
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_grant", 32'(bus4.grant), 32'd0);
            chk("rst_busy",  32'(bus4.busy),  32'd0);
            chk("rst_wdata", 32'(bus4.wr_data), 32'd0);
        end
        reset = 1'b1;
        step();
        chk("first_grant", 32'(bus4.grant), 32'h1);

        // Fairness with all four requesting continuously
        n_done = 0;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (bus4.done != 4'd0) n_done++;
            if (s % 3 == 0) chk("rr_order", 32'(bus4.grant), 32'(1 << ((s / 3) % 4)));
        end
        chk("rr_done_cnt", 32'(n_done), 32'd4);
        bus4.req = 4'b0000;
        step();
        step();

        // Single write from requester 2
        set_slot(2, 2'd3, 8'hA5);
        bus4.req = 4'b0100;
        step();
        chk("sw_grant", 32'(bus4.grant),   32'h4);
        chk("sw_wr_en", 32'(bus4.wr_en),   32'h8);
        chk("sw_wdata", 32'(bus4.wr_data), 32'hA5);
        bus4.req = 4'b0000;
        step();
        chk("sw_done",  32'(bus4.done),  32'h4);
        chk("sw_wr_en0", 32'(bus4.wr_en), 32'h0);
        step();
        chk("sw_idle",  32'(bus4.busy),  32'h0);

        // Address/data latched at arbitration
        set_slot(1, 2'd1, 8'h3C);
        bus4.req = 4'b0010;
        step();
        chk("lat_wdata", 32'(bus4.wr_data), 32'h3C);
        chk("lat_wr_en", 32'(bus4.wr_en),   32'h2);
        set_slot(1, 2'd1, 8'hFF);
        bus4.req = 4'b0000;
        step();
        chk("lat_done", 32'(bus4.done), 32'h2);
        step();

        // Out-of-range address on the DEPTH=3 instance
        set_slot(0, 2'd3, 8'h5A);
        bus4.req = 4'b0001;
        step();
        chk("oor_wr_en_a", 32'(bus3.wr_en), 32'h0);
        chk("oor_busy_a",  32'(bus3.busy),  32'h1);
        bus4.req = 4'b0000;
        step();
        chk("oor_done",    32'(bus3.done),  32'h1);
        chk("oor_busy_b",  32'(bus3.busy),  32'h1);
        step();
        chk("oor_busy_c",  32'(bus3.busy),  32'h0);

        // Reset at the edge ending WRITE
        set_slot(2, 2'd0, 8'h77);
        bus4.req = 4'b0100;
        step();
        reset = 1'b0;
        step();
        chk("mr_grant", 32'(bus4.grant), 32'h0);
        chk("mr_done",  32'(bus4.done),  32'h0);
        chk("mr_wr_en", 32'(bus4.wr_en), 32'h0);
        chk("mr_busy",  32'(bus4.busy),  32'h0);
        reset    = 1'b1;
        bus4.req = 4'b0010;
        step();
        chk("mr_regrant", 32'(bus4.grant), 32'h2);
        bus4.req = 4'b0000;
        step();
        step();

        // Random traffic, with occasional resets
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 49) != 0);
            bus4.req      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus4.req_addr = 8'($urandom);
            bus4.req_data = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
